// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV M-extension multiply/divide unit:
// funct3 operation codes, FSM state encoding and the most-negative-value
// constant, sized for the widest legal XLEN so each instance slices its own.
package muldiv_pkg;

  localparam logic [2:0] MD_OP_MUL    = 3'b000;
  localparam logic [2:0] MD_OP_MULH   = 3'b001;
  localparam logic [2:0] MD_OP_MULHSU = 3'b010;
  localparam logic [2:0] MD_OP_MULHU  = 3'b011;
  localparam logic [2:0] MD_OP_DIV    = 3'b100;
  localparam logic [2:0] MD_OP_DIVU   = 3'b101;
  localparam logic [2:0] MD_OP_REM    = 3'b110;
  localparam logic [2:0] MD_OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_PREP = 2'd1,
    MD_ST_CALC = 2'd2,
    MD_ST_FIX  = 2'd3
  } md_state_t;

  // Only the MSB is set; an XLEN-wide instance takes the top XLEN bits.
  localparam int MD_MAX_XLEN = 64;
  localparam logic [MD_MAX_XLEN-1:0] MD_MOST_NEG_MAX = {1'b1, {(MD_MAX_XLEN-1){1'b0}}};

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and muldiv_unit.
// master: start, kill, op, a, b out; busy, done, result in.
// slave : the unit side (mirror image).
interface muldiv_if #(parameter int XLEN = 64);
  logic            start;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, kill, op, a, b, input busy, done, result);
  modport slave  (input start, kill, op, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_shift_core.sv
// Shared shift datapath: radix-2 shift-add multiply or restoring divide, one bit per step.
// Latency: one step per cycle with step=1; load seeds the accumulator in one cycle.
// No handshake; the controlling FSM decides when to load and step.
// Ports: clk, rst, load (seed acc/operand), step (advance one bit), is_div,
//        mag_a/mag_b (unsigned magnitudes), acc_out (product, or {rem, quo}).
module muldiv_shift_core #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  output logic [2*XLEN-1:0] acc_out
);

  localparam int W2 = 2 * XLEN;

  // Upper XLEN+1 bits: running partial product (with carry) or partial remainder;
  // lower XLEN bits: multiplier being shifted out, or dividend shifting in quotient bits.
  logic [W2:0]     acc;
  logic [XLEN-1:0] opnd;
  logic [XLEN:0]   add_sum;
  logic [W2:0]     acc_sh;
  logic [XLEN+1:0] trial;
  logic [W2:0]     acc_nxt;

  always_comb begin
    add_sum = acc[W2:XLEN] + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    acc_sh  = {acc[W2-1:0], 1'b0};
    // Extra top bit turns the subtraction borrow into a sign bit.
    trial   = {1'b0, acc_sh[W2:XLEN]} - {2'b00, opnd};
    if (is_div) begin
      acc_nxt = trial[XLEN+1] ? acc_sh : {trial[XLEN:0], acc_sh[XLEN-1:1], 1'b1};
    end else begin
      acc_nxt = {1'b0, add_sum, acc[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= {{(XLEN+1){1'b0}}, mag_a};
      opnd <= mag_b;
    end else if (step) begin
      acc  <= acc_nxt;
    end
  end

  assign acc_out = acc[W2-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide engine (MUL..REMU) with RISC-V corner results.
// Latency: XLEN+2 cycles from accept to done; 2 cycles for divide-by-zero/overflow.
// Backpressure: start ignored while busy (not queued); kill aborts with no done.
// Ports: clk, rst (async, active-high), io (muldiv_if.slave: start/kill/op/a/b in,
//        busy/done/result out; result held until the next done).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  io
);

  localparam int W2 = 2 * XLEN;
  localparam logic [XLEN-1:0] MOST_NEG = MD_MOST_NEG_MAX[MD_MAX_XLEN-1 -: XLEN];

  md_state_t       state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, cnt;
  logic            res_neg;

  logic            signed_a, signed_b, sgn_a, sgn_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            is_div, div_zero, div_ovf, special, neg_now;
  logic [XLEN-1:0] special_val, quo, rem, fix_val;
  logic [W2-1:0]   acc, prod_fix;

  always_comb begin
    signed_a = (op_q == MD_OP_MULH) || (op_q == MD_OP_MULHSU) ||
               (op_q == MD_OP_DIV)  || (op_q == MD_OP_REM);
    signed_b = (op_q == MD_OP_MULH) || (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);
    sgn_a    = signed_a & a_q[XLEN-1];
    sgn_b    = signed_b & b_q[XLEN-1];
    mag_a    = sgn_a ? -a_q : a_q;
    mag_b    = sgn_b ? -b_q : b_q;
    is_div   = op_q[2];
    div_zero = is_div && (b_q == '0);
    div_ovf  = ((op_q == MD_OP_DIV) || (op_q == MD_OP_REM)) &&
               (a_q == MOST_NEG) && (b_q == '1);
    special  = div_zero || div_ovf;
    // op_q[1] separates remainder ops from quotient ops.
    if (div_zero) special_val = op_q[1] ? a_q : '1;
    else          special_val = op_q[1] ? '0  : a_q;
    // Remainder follows the dividend's sign; everything else takes the sign product.
    neg_now  = (is_div && op_q[1]) ? sgn_a : (sgn_a ^ sgn_b);
  end

  muldiv_shift_core #(.XLEN(XLEN)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (state == MD_ST_PREP),
    .step    (state == MD_ST_CALC),
    .is_div  (is_div),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .acc_out (acc)
  );

  always_comb begin
    prod_fix = res_neg ? -acc : acc;
    quo      = acc[XLEN-1:0];
    rem      = acc[W2-1:XLEN];
    fix_val  = '0;
    if (special) begin
      fix_val = special_val;
    end else begin
      case (op_q)
        MD_OP_MUL:                           fix_val = prod_fix[XLEN-1:0];
        MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: fix_val = prod_fix[W2-1:XLEN];
        MD_OP_DIV, MD_OP_DIVU:               fix_val = res_neg ? -quo : quo;
        default:                             fix_val = res_neg ? -rem : rem;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MD_ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      res_neg   <= 1'b0;
      io.busy   <= 1'b0;
      io.done   <= 1'b0;
      io.result <= '0;
    end else begin
      io.done <= 1'b0;
      if (state != MD_ST_IDLE && io.kill) begin
        state   <= MD_ST_IDLE;
        io.busy <= 1'b0;
      end else begin
        case (state)
          MD_ST_IDLE: begin
            // busy is still high in the done cycle, so no accept there.
            if (io.start && !io.busy && !io.kill) begin
              op_q    <= io.op;
              a_q     <= io.a;
              b_q     <= io.b;
              io.busy <= 1'b1;
              state   <= MD_ST_PREP;
            end else begin
              io.busy <= 1'b0;
            end
          end
          MD_ST_PREP: begin
            res_neg <= neg_now;
            cnt     <= '0;
            state   <= special ? MD_ST_FIX : MD_ST_CALC;
          end
          MD_ST_CALC: begin
            cnt <= cnt + XLEN'(1);
            if (cnt == XLEN'(XLEN - 1)) state <= MD_ST_FIX;
          end
          default: begin
            io.result <= fix_val;
            io.done   <= 1'b1;
            state     <= MD_ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
